// File: rtl/pc_fetch.sv
// Instruction-byte prefetch unit.
//
// Keeps an architectural PC (address of the byte presented on irout) and a
// separate fetch PC that runs ahead, filling a small FIFO from a simple
// request/acknowledge byte memory. The control unit consumes bytes with pcc
// and redirects the stream with jmp.
//
// Memory handshake: the request is a Moore output of the FSM. An IDLE cycle
// decides whether to fetch, and the following REQ cycle(s) hold mem_req and
// mem_addr until mem_ack. With a zero-wait memory this gives one byte every
// two cycles. A jump that lands while a read is outstanding cannot cancel
// the bus cycle. The FSM therefore parks in DROP, keeps the old address on
// the bus, and throws the returning byte away.
module pc_fetch #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcc,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        irout,
  output logic              ir_valid,
  output logic              stall,
  output logic [ADDR_W-1:0] pc
);

  // DEPTH is a power of two, so the pointers wrap naturally in PTR_W bits.
  // The count needs one extra bit so that it can represent "full".
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              stall_q, stall_d;
  logic [7:0]        fifo_q [DEPTH];

  logic              push;
  logic              pop;
  logic              not_empty;

  assign not_empty = (count_q != '0);

  // A pop needs a byte to be present. A jump overrides the consume strobe in
  // the same cycle.
  assign pop = pcc && !jmp && not_empty;

  // Fetch FSM: decide when to issue a read, wait for it, or discard it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        // Nothing is in flight while idle, so the FIFO occupancy alone
        // decides whether there is room for another byte.
        if (!jmp && (count_q < DEPTH_C)) begin
          state_d = REQ;
          addr_d  = fpc_q;
        end
      end
      REQ: begin
        if (mem_ack) begin
          // A jump in the ack cycle makes this byte stale, so it is dropped.
          state_d = IDLE;
          push    = !jmp;
        end else if (jmp) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The returning byte belongs to the old stream and is discarded.
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter and FIFO pointer updates. A jump flushes everything.
  always_comb begin
    pc_d     = pc_q;
    fpc_d    = fpc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    stall_d  = pcc && !jmp && !not_empty;
    if (jmp) begin
      pc_d     = jmp_addr;
      fpc_d    = jmp_addr;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (pop) begin
        pc_d     = pc_q + ADDR_W'(1);
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        fpc_d    = fpc_q + ADDR_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      // A simultaneous push and pop leaves the count unchanged.
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State, counter and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      fpc_q    <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fpc_q    <= fpc_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      stall_q  <= stall_d;
    end
  end

  // FIFO storage. A write happens only on an accepted read, and the
  // request gating guarantees that the FIFO has room for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 8'h00;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign mem_req  = (state_q != IDLE);
  assign mem_addr = addr_q;
  assign ir_valid = not_empty;
  // The head byte is forced to zero when the FIFO is empty. This makes irout
  // read 0x00 out of reset.
  assign irout    = not_empty ? fifo_q[rd_ptr_q] : 8'h00;
  assign stall    = stall_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch. The stimulus queues the expected memory
// requests and consumed bytes. A monitor on the falling edge pops and
// compares each time the DUT issues a new request or a byte is consumed.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcc;
  logic        jmp;
  logic [15:0] jmp_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  irout;
  logic        ir_valid;
  logic        stall;
  logic [15:0] pc;

  int total  = 0;
  int passed = 0;

  // Memory model controls.
  int   wait_cfg  = 0;
  int   wait_cnt  = 0;
  logic force_ack = 1'b0;
  logic prev_req  = 1'b0;

  logic [15:0] exp_addr_q [$];
  logic [7:0]  exp_byte_q [$];
  logic [15:0] exp_pc_q   [$];

  pc_fetch #(.ADDR_W(16), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .pcc       (pcc),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .irout     (irout),
    .ir_valid  (ir_valid),
    .stall     (stall),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_req(input logic [15:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic exp_use(input logic [7:0] b, input logic [15:0] p);
    exp_byte_q.push_back(b);
    exp_pc_q.push_back(p);
  endtask

  // Memory model plus monitor. Inputs change just after the rising edge, so
  // the falling edge sees this cycle's inputs and outputs together.
  always @(negedge clk) begin
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_addr[7:0];
      wait_cnt  = 0;
    end else if (mem_req) begin
      if (wait_cnt >= wait_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr[7:0];
        wait_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'hEE;
      wait_cnt  = 0;
    end

    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
      $display("req  addr=0x%04h", mem_addr);
      if (exp_addr_q.size() == 0) begin
        total++;
        $display("FAIL req_unexpected: got addr 0x%04h, expected no request", mem_addr);
      end else begin
        chk("req_addr", {16'h0, mem_addr}, {16'h0, exp_addr_q.pop_front()});
      end
    end
    prev_req = mem_req;

    if (pcc && !jmp && !rst && ir_valid === 1'b1) begin
      $display("use  byte=0x%02h pc=0x%04h", irout, pc);
      if (exp_byte_q.size() == 0) begin
        total++;
        $display("FAIL use_unexpected: got byte 0x%02h, expected no consume", irout);
      end else begin
        chk("use_byte", {24'h0, irout}, {24'h0, exp_byte_q.pop_front()});
        chk("use_pc", {16'h0, pc}, {16'h0, exp_pc_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; pcc = 1'b0; jmp = 1'b0; jmp_addr = 16'h0;
    mem_ack = 1'b0; mem_rdata = 8'hEE;
    cyc(2);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_irout", {24'h0, irout}, 32'h0);
    chk("rst_pc", {16'h0, pc}, 32'h0);

    // Fill from address 0 with a zero-wait memory and no consumption.
    exp_req(16'h0000); exp_req(16'h0001);
    rst = 1'b0;
    cyc(1);
    chk("first_req", {31'h0, mem_req}, 32'h1);
    chk("first_addr", {16'h0, mem_addr}, 32'h0);
    chk("first_valid", {31'h0, ir_valid}, 32'h0);
    cyc(1);
    chk("c2_valid", {31'h0, ir_valid}, 32'h1);
    chk("c2_irout", {24'h0, irout}, 32'h0);
    chk("c2_pc", {16'h0, pc}, 32'h0);
    cyc(8);
    chk("full_no_req", {31'h0, mem_req}, 32'h0);

    // Consume bytes. The third pcc lands on a push, so the count holds.
    exp_use(8'h00, 16'h0000); exp_use(8'h01, 16'h0001); exp_use(8'h02, 16'h0002);
    exp_req(16'h0002); exp_req(16'h0003); exp_req(16'h0004);
    pcc = 1'b1; cyc(2);
    pcc = 1'b0; cyc(2);
    pcc = 1'b1; cyc(1);
    pcc = 1'b0;
    chk("pushpop_pc", {16'h0, pc}, 32'h3);
    chk("pushpop_irout", {24'h0, irout}, 32'h03);
    chk("pushpop_valid", {31'h0, ir_valid}, 32'h1);
    cyc(6);
    chk("refill_idle", {31'h0, mem_req}, 32'h0);

    // A consume on an empty FIFO right after a jump raises stall.
    exp_req(16'h0180); exp_req(16'h0181);
    jmp = 1'b1; jmp_addr = 16'h0180; cyc(1);
    jmp = 1'b0; pcc = 1'b1; cyc(1);
    pcc = 1'b0;
    chk("stall_set", {31'h0, stall}, 32'h1);
    chk("stall_pc", {16'h0, pc}, 32'h0180);
    chk("stall_valid", {31'h0, ir_valid}, 32'h0);
    cyc(1);
    chk("stall_clear", {31'h0, stall}, 32'h0);
    chk("jmp_first_byte", {24'h0, irout}, 32'h80);
    cyc(6);

    // A jump while a slow read is outstanding.
    wait_cfg = 3;
    exp_use(8'h80, 16'h0180);
    exp_req(16'h0182); exp_req(16'h1234); exp_req(16'h1235);
    pcc = 1'b1; cyc(1);
    pcc = 1'b0; cyc(1);
    chk("slow_req", {31'h0, mem_req}, 32'h1);
    jmp = 1'b1; jmp_addr = 16'h1234; cyc(1);
    jmp = 1'b0;
    chk("drop_req_held", {31'h0, mem_req}, 32'h1);
    chk("drop_addr_held", {16'h0, mem_addr}, 32'h0182);
    chk("drop_pc", {16'h0, pc}, 32'h1234);
    chk("drop_valid", {31'h0, ir_valid}, 32'h0);
    cyc(3);
    chk("drop_done_req", {31'h0, mem_req}, 32'h0);
    chk("drop_discarded", {31'h0, ir_valid}, 32'h0);
    cyc(20);
    chk("jmp_valid", {31'h0, ir_valid}, 32'h1);
    chk("jmp_irout", {24'h0, irout}, 32'h34);
    chk("jmp_pc", {16'h0, pc}, 32'h1234);

    // Wrap the PC through 0xFFFF.
    wait_cfg = 0;
    exp_req(16'hFFFF); exp_req(16'h0000);
    jmp = 1'b1; jmp_addr = 16'hFFFF; cyc(1);
    jmp = 1'b0;
    chk("wrap_pc0", {16'h0, pc}, 32'hFFFF);
    cyc(6);
    exp_use(8'hFF, 16'hFFFF); exp_use(8'h00, 16'h0000);
    exp_req(16'h0001); exp_req(16'h0002);
    pcc = 1'b1; cyc(1);
    chk("wrap_pc1", {16'h0, pc}, 32'h0000);
    cyc(1);
    pcc = 1'b0;
    chk("wrap_pc2", {16'h0, pc}, 32'h0001);
    cyc(8);
    chk("wrap_irout", {24'h0, irout}, 32'h01);

    // Reset during a request, coinciding with the acknowledge.
    wait_cfg = 100;
    exp_use(8'h01, 16'h0001);
    exp_req(16'h0003);
    pcc = 1'b1; cyc(1);
    pcc = 1'b0; cyc(1);
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b1; force_ack = 1'b1; cyc(1);
    force_ack = 1'b0;
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_valid", {31'h0, ir_valid}, 32'h0);
    chk("mid_rst_pc", {16'h0, pc}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    chk("mid_rst_irout", {24'h0, irout}, 32'h0);
    // A stray acknowledge with no request pending must be ignored.
    wait_cfg = 0;
    exp_req(16'h0000); exp_req(16'h0001);
    rst = 1'b0; force_ack = 1'b1; cyc(1);
    force_ack = 1'b0;
    chk("stray_ack_valid", {31'h0, ir_valid}, 32'h0);
    chk("post_rst_req", {31'h0, mem_req}, 32'h1);
    chk("post_rst_addr", {16'h0, mem_addr}, 32'h0);
    cyc(8);
    chk("post_rst_irout", {24'h0, irout}, 32'h0);
    chk("post_rst_pc", {16'h0, pc}, 32'h0);

    chk("addr_queue_drained", exp_addr_q.size(), 32'h0);
    chk("use_queue_drained", exp_byte_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, program-counter and memory-address width.
REQ-002 SHALL have parameter DEPTH, default 2, prefetch buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pcc  input  1  control-unit consume strobe: take the head byte and advance PC.
REQ-006 SHALL have port jmp  input  1  jump strobe: load PC from jmp_addr and flush the prefetch buffer.
REQ-007 SHALL have port jmp_addr  input  ADDR_W  jump target.
REQ-008 SHALL have port mem_req  output  1  memory read request.
REQ-009 SHALL have port mem_addr  output  ADDR_W  read address; valid while mem_req=1.
REQ-010 SHALL have port mem_ack  input  1  read complete; mem_rdata valid in the same cycle.
REQ-011 SHALL have port mem_rdata  input  8  read data.
REQ-012 SHALL have port irout  output  8  head-of-buffer byte, feeding the control unit's irin.
REQ-013 SHALL have port ir_valid  output  1  irout holds a valid byte.
REQ-014 SHALL have port stall  output  1  pcc was asserted while the buffer was empty (registered, one cycle).
REQ-015 SHALL have port pc  output  ADDR_W  architectural PC: address of the byte on irout.

Function
REQ-016 SHALL keep two counters: pc (architectural) and fpc (next fetch address), plus a DEPTH-entry FIFO with a count.
REQ-017 SHALL implement FSM states IDLE, REQ and DROP.
REQ-018 In IDLE, SHALL go to REQ and drive mem_req=1, mem_addr=fpc when count + in-flight < DEPTH and jmp=0.
REQ-019 In REQ, SHALL hold mem_req=1 and mem_addr stable until a cycle with mem_ack=1.
REQ-020 On mem_ack in REQ, SHALL push mem_rdata, set fpc to fpc+1 (mod 2^ADDR_W), and return to IDLE.
REQ-021 SHALL allow mem_ack in the same cycle mem_req first rises (zero-wait memory), giving one byte per two cycles.
REQ-022 ir_valid SHALL equal (count != 0); irout SHALL show the FIFO head and is don't-care when ir_valid=0.
REQ-023 On pcc=1 with ir_valid=1, SHALL pop the head and set pc to pc+1 (mod 2^ADDR_W).
REQ-024 On pcc=1 with ir_valid=0, SHALL leave pc and FIFO unchanged and set stall=1 for the next cycle.
REQ-025 On a push and a pop in the same cycle, count SHALL stay unchanged and data order SHALL be preserved.
REQ-026 The FIFO SHALL never overflow; no request is issued when full (REQ-018).
REQ-027 On jmp=1, SHALL set pc and fpc to jmp_addr, set count to 0, and ignore pcc in that cycle (jmp has priority).
REQ-028 On jmp=1 in REQ with mem_ack=0, SHALL go to DROP, keeping mem_req=1 and the old mem_addr until ack.
REQ-029 On jmp=1 in REQ with mem_ack=1, SHALL discard mem_rdata, leave fpc=jmp_addr, and go to IDLE.
REQ-030 In DROP, on mem_ack SHALL discard data, go to IDLE, and not change fpc.
REQ-031 In DROP, a further jmp SHALL reload pc and fpc and stay in DROP.
REQ-032 pc and fpc SHALL wrap from 2^ADDR_W-1 to 0 without error.

Reset
REQ-033 With rst=1 at a clock edge, SHALL set pc=0, fpc=0, count=0, state=IDLE, mem_req=0, ir_valid=0, stall=0 and irout=0x00.
REQ-034 rst SHALL override jmp, pcc and mem_ack in the same cycle.
REQ-035 Reset during REQ SHALL drop mem_req immediately; a later mem_ack with no request pending SHALL be ignored.
REQ-036 The first request after reset SHALL be for address 0x0000, in the first cycle after rst deasserts.

Verification
REQ-037 Reset, then zero-wait memory returning addr[7:0]: irout 0x00 then 0x01; ir_valid high by cycle 2; pc=0 then 1 after each pcc.
REQ-038 With no pcc and DEPTH=2: exactly two requests (0x0000, 0x0001); mem_req then stays 0 until a pcc pops an entry.
REQ-039 pcc with an empty FIFO: stall=1 for one cycle; pc unchanged.
REQ-040 jmp to 0x1234 while REQ waits 3 cycles for ack: old address held until ack and data discarded; next request is 0x1234; pc=0x1234; ir_valid=0 until it returns.
REQ-041 jmp to 0xFFFF, then two pcc: pc goes 0xFFFF, 0x0000, 0x0001; requests issue for 0xFFFF then 0x0000.
REQ-042 rst asserted mid-REQ together with mem_ack: all outputs take reset values; nothing pushed.
